// File: rtl/pwm_feeder_pkg.sv
// -----------------------------------------------------------------------------
// pwm_feeder_pkg
// Purpose : shared register map, register bit positions and reset constants
//           for the PWM sample feeder.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package pwm_feeder_pkg;

  // Register select, decoded from addr[3:2]
  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_DIVIDER = 2'd2,
    REG_CTRL    = 2'd3
  } reg_sel_e;

  // STATUS bit positions (LEVEL occupies [7:0])
  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_OVF   = 10;
  localparam int ST_UNF   = 11;

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  // 255 gives a 256-cycle sample period: one frame of an 8-bit PWM
  localparam logic [31:0] DIVIDER_RESET = 32'd255;

endpackage

// File: rtl/pwm_sample_feeder_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Purpose : single-clock FIFO with occupancy count and synchronous flush,
//           usable by any streaming peripheral.
// Ports   : clk, resetn (sync active-low)
//           flush            - empties the FIFO, overrides push/pop
//           push, wdata      - write request; accepted when not full, or when
//                              full with a same-cycle pop
//           pop, rdata       - read request; rdata shows the head entry
//           full, empty, level
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_level == LW'(DEPTH));
  assign empty = (r_level == LW'(0));
  assign level = r_level;
  assign rdata = r_mem[r_rd_ptr];

  // Qualify push/pop; a pop frees the slot a same-cycle push into a full FIFO needs
  always_comb begin
    w_do_push = 1'b0;
    w_do_pop  = 1'b0;
    if (flush) begin
      w_do_push = 1'b0;
      w_do_pop  = 1'b0;
    end else begin
      w_do_pop  = pop && !empty;
      w_do_push = push && (!full || w_do_pop);
    end
  end

  // Storage array write
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_level  <= LW'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/pwm_sample_feeder.sv
// -----------------------------------------------------------------------------
// pwm_sample_feeder
// Purpose : bus-mapped sample FIFO that hands one 8-bit duty value per
//           programmable sample period to the PWM stage (simple DAC).
// Ports   : clk, resetn (sync active-low)
//           valid/ready, wstrb, addr, wdata, rdata - native memory bus slave
//           duty, duty_valid, duty_ready           - sample stream to PWM
//           irq                                    - low-water interrupt
// Config  : define PWM_FEEDER_IRQ_EN to build the IRQ_EN bit and low-water
//           interrupt; otherwise irq is tied low and IRQ_EN reads 0.
// -----------------------------------------------------------------------------
module pwm_sample_feeder
  import pwm_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  duty,
  output logic        duty_valid,
  input  logic        duty_ready,
  output logic        irq
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic             r_ready;
  logic [31:0]      r_rdata;
  logic [7:0]       r_duty;
  logic             r_duty_valid;
  logic             r_ovf;
  logic             r_unf;
  logic             r_en;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;

  logic             w_req;
  logic             w_is_write;
  reg_sel_e         w_sel;
  logic [31:0]      w_rd_data;
  logic [31:0]      w_status;
  logic [31:0]      w_ctrl_rd;
  logic [31:0]      w_wmask;
  logic [31:0]      w_div_merge;
  logic             w_push;
  logic             w_flush;
  logic             w_div_wr;
  logic             w_ctrl_wr;
  logic             w_w1c_ovf;
  logic             w_w1c_unf;
  logic             w_tick;
  logic             w_fire;
  logic             w_pop;
  logic             w_unf_set;
  logic             w_ovf_set;
  logic             w_irq_en_bit;
  logic [7:0]       w_fifo_rdata;
  logic             w_full;
  logic             w_empty;
  logic [LW-1:0]    w_level;
  logic             w_unused_bits;

  // A transaction acts only in the first cycle of valid
  assign w_req      = valid && !r_ready;
  assign w_is_write = (wstrb != 4'd0);
  assign w_sel      = reg_sel_e'(addr[3:2]);

  assign w_status  = {16'd0, 4'd0, r_unf, r_ovf, w_full, w_empty, 8'(w_level)};
  assign w_ctrl_rd = {29'd0, w_irq_en_bit, 1'b0, r_en};

  // Byte-strobe merge for the divider register
  assign w_wmask     = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign w_div_merge = (32'(r_div) & ~w_wmask) | (wdata & w_wmask);

  // Rate divider tick; >= lets a shrunken divider wrap an overshooting counter
  assign w_tick    = r_en && (r_cnt >= r_div);
  assign w_fire    = w_tick && !w_flush;
  assign w_pop     = w_fire && !r_duty_valid && !w_empty;
  assign w_unf_set = w_fire && !r_duty_valid && w_empty;
  // A push into a full FIFO survives only if a pop frees a slot the same cycle
  assign w_ovf_set = w_push && w_full && !w_pop;

  assign w_unused_bits = ^{addr[31:4], addr[1:0], wdata, wstrb, w_div_merge};

  // Register decode: side-effect strobes and read data for the current request
  always_comb begin
    w_push    = 1'b0;
    w_flush   = 1'b0;
    w_div_wr  = 1'b0;
    w_ctrl_wr = 1'b0;
    w_w1c_ovf = 1'b0;
    w_w1c_unf = 1'b0;
    w_rd_data = 32'd0;
    if (w_req) begin
      case (w_sel)
        REG_DATA: begin
          w_push = w_is_write && wstrb[0];
        end
        REG_STATUS: begin
          if (w_is_write) begin
            w_w1c_ovf = wstrb[1] && wdata[ST_OVF];
            w_w1c_unf = wstrb[1] && wdata[ST_UNF];
          end else begin
            w_rd_data = w_status;
          end
        end
        REG_DIVIDER: begin
          if (w_is_write) begin
            w_div_wr = 1'b1;
          end else begin
            w_rd_data = 32'(r_div);
          end
        end
        REG_CTRL: begin
          if (w_is_write) begin
            w_ctrl_wr = wstrb[0];
            w_flush   = wstrb[0] && wdata[CTRL_FLUSH];
          end else begin
            w_rd_data = w_ctrl_rd;
          end
        end
        default: begin
          w_rd_data = 32'd0;
        end
      endcase
    end else begin
      w_rd_data = 32'd0;
    end
  end

  // Bus handshake, read data and configuration registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
      r_div   <= DIVIDER_RESET[DIV_W-1:0];
      r_en    <= 1'b0;
    end else begin
      r_ready <= w_req;
      if (w_req) begin
        r_rdata <= w_rd_data;
      end
      if (w_div_wr) begin
        r_div <= w_div_merge[DIV_W-1:0];
      end
      if (w_ctrl_wr) begin
        r_en <= wdata[CTRL_EN];
      end
    end
  end

  // Sample-period counter: held at 0 while disabled or flushed
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= DIV_W'(0);
    end else if (w_flush || !r_en || w_tick) begin
      r_cnt <= DIV_W'(0);
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  // Output sample register; duty keeps its last value when the slot empties
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_duty       <= 8'd0;
      r_duty_valid <= 1'b0;
    end else if (w_flush) begin
      r_duty_valid <= 1'b0;
    end else if (w_pop) begin
      r_duty       <= w_fifo_rdata;
      r_duty_valid <= 1'b1;
    end else if (r_duty_valid && duty_ready) begin
      r_duty_valid <= 1'b0;
    end
  end

  // Sticky error flags; a same-cycle set wins over a W1C clear
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_w1c_ovf) begin
        r_ovf <= 1'b0;
      end
      if (w_unf_set) begin
        r_unf <= 1'b1;
      end else if (w_w1c_unf) begin
        r_unf <= 1'b0;
      end
    end
  end

`ifdef PWM_FEEDER_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  // Low-water interrupt: FIFO at or below half, or an underrun seen
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_irq_en <= wdata[CTRL_IRQ_EN];
      end
      r_irq <= r_irq_en && ((w_level <= LW'(DEPTH / 2)) || r_unf);
    end
  end

  assign w_irq_en_bit = r_irq_en;
  assign irq          = r_irq;
`else
  assign w_irq_en_bit = 1'b0;
  assign irq          = 1'b0;
`endif

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (w_flush),
    .push   (w_push),
    .pop    (w_pop),
    .wdata  (wdata[7:0]),
    .rdata  (w_fifo_rdata),
    .full   (w_full),
    .empty  (w_empty),
    .level  (w_level)
  );

  assign ready      = r_ready;
  assign rdata      = r_rdata;
  assign duty       = r_duty;
  assign duty_valid = r_duty_valid;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_pwm_sample_feeder
// Purpose : directed self-checking bench for pwm_sample_feeder (DEPTH=16,
//           DIV_W=16). Builds with or without PWM_FEEDER_IRQ_EN.
// -----------------------------------------------------------------------------
module tb_pwm_sample_feeder;

  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;
  localparam logic [31:0] A_DIV  = 32'h8;
  localparam logic [31:0] A_CTRL = 32'hC;

`ifdef PWM_FEEDER_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [7:0]  duty;
  logic        duty_valid;
  logic        duty_ready = 1'b0;
  logic        irq;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pwm_sample_feeder #(
    .DEPTH (16),
    .DIV_W (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .valid      (valid),
    .ready      (ready),
    .wstrb      (wstrb),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .duty       (duty),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    int n;
    @(negedge clk);
    valid = 1'b1;
    addr  = a;
    wdata = d;
    wstrb = s;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 8);
    chk("bus_ready", {31'd0, ready}, 32'd1);
    rd    = rdata;
    valid = 1'b0;
    wstrb = 4'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] x;
    bus(a, d, 4'hF, x);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] x;
    bus(a, 32'd0, 4'd0, x);
    chk(tag, x, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seen_val [4];
    int         seen_idx [4];
    int         k;
    int         n;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_duty", {24'd0, duty}, 32'd0);
    chk("rst_dvalid", {31'd0, duty_valid}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    rd_chk("rst_status", A_STAT, 32'h0000_0100);
    rd_chk("rst_div", A_DIV, 32'd255);
    rd_chk("rst_ctrl", A_CTRL, 32'd0);
    rd_chk("data_rd0", A_DATA, 32'd0);

    // IRQ_EN only sticks when the interrupt is built in
    wr(A_CTRL, 32'h4);
    rd_chk("ctrl_irqen", A_CTRL, IRQ_BUILD ? 32'h4 : 32'h0);
    wr(A_CTRL, 32'h0);

    // Byte-strobed divider writes
    begin
      logic [31:0] x;
      bus(A_DIV, 32'h0000_ABCD, 4'b0001, x);
      rd_chk("div_b0", A_DIV, 32'h0000_00CD);
      bus(A_DIV, 32'h0000_1200, 4'b0010, x);
      rd_chk("div_b1", A_DIV, 32'h0000_12CD);
    end

    // ---------------- streaming at DIVIDER=3 ----------------
    wr(A_DIV, 32'd3);
    wr(A_DATA, 32'h10);
    wr(A_DATA, 32'h80);
    wr(A_DATA, 32'hFF);
    rd_chk("lvl3", A_STAT, 32'h0000_0003);
    duty_ready = 1'b1;
    wr(A_CTRL, 32'h1);
    k = 0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (duty_valid) begin
        if (k < 4) begin
          seen_val[k] = duty;
          seen_idx[k] = i;
        end
        k++;
      end
    end
    chk("stream_cnt", k, 32'd3);
    chk("stream_v0", {24'd0, seen_val[0]}, 32'h10);
    chk("stream_v1", {24'd0, seen_val[1]}, 32'h80);
    chk("stream_v2", {24'd0, seen_val[2]}, 32'hFF);
    chk("stream_t0", seen_idx[0], 32'd5);
    chk("stream_gap1", seen_idx[1] - seen_idx[0], 32'd4);
    chk("stream_gap2", seen_idx[2] - seen_idx[1], 32'd4);
    chk("stream_hold", {24'd0, duty}, 32'hFF);
    rd_chk("unf_set", A_STAT, 32'h0000_0900);
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h800);
    rd_chk("unf_clr", A_STAT, 32'h0000_0100);

    // ---------------- overflow with EN=0 ----------------
    for (int i = 0; i < 17; i++) begin
      wr(A_DATA, 32'(i + 1));
    end
    rd_chk("ovf_full", A_STAT, 32'h0000_0610);
    wr(A_STAT, 32'h400);
    rd_chk("ovf_w1c", A_STAT, 32'h0000_0210);
    wr(A_CTRL, 32'h2);
    rd_chk("flush_empty", A_STAT, 32'h0000_0100);
    rd_chk("flush_rd0", A_CTRL, 32'h0);

    // ---------------- stall with duty_ready=0 ----------------
    duty_ready = 1'b0;
    wr(A_DATA, 32'h21);
    wr(A_DATA, 32'h42);
    wr(A_CTRL, 32'h1);
    repeat (16) @(negedge clk);
    chk("stall_duty", {24'd0, duty}, 32'h21);
    chk("stall_valid", {31'd0, duty_valid}, 32'd1);
    rd_chk("stall_stat", A_STAT, 32'h0000_0001);
    @(negedge clk);
    duty_ready = 1'b1;
    n = 0;
    while (duty !== 8'h42 && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("release_duty", {24'd0, duty}, 32'h42);
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'hC00);
    rd_chk("release_stat", A_STAT, 32'h0000_0100);

    // ---------------- FLUSH with duty_valid=1 ----------------
    duty_ready = 1'b0;
    wr(A_DIV, 32'd0);
    for (int i = 0; i < 6; i++) begin
      wr(A_DATA, 32'h51 + 32'(i));
    end
    wr(A_CTRL, 32'h1);
    rd_chk("pre_flush", A_STAT, 32'h0000_0005);
    chk("pre_flush_dv", {31'd0, duty_valid}, 32'd1);
    wr(A_CTRL, 32'h2);
    chk("flush_dv", {31'd0, duty_valid}, 32'd0);
    chk("flush_duty", {24'd0, duty}, 32'h51);
    rd_chk("flush_stat", A_STAT, 32'h0000_0100);

    // ---------------- low-water interrupt ----------------
    for (int i = 0; i < 9; i++) begin
      wr(A_DATA, 32'h60 + 32'(i));
    end
    wr(A_CTRL, 32'h4);
    repeat (2) @(negedge clk);
    chk("irq_lvl9", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 32'h5);
    repeat (3) @(negedge clk);
    chk("irq_lvl8", {31'd0, irq}, {31'd0, IRQ_BUILD});
    rd_chk("irq_stat", A_STAT, 32'h0000_0008);
    wr(A_DATA, 32'h70);
    repeat (2) @(negedge clk);
    chk("irq_relvl9", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
